// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: pipeline trace capture unit.
// Captures one snapshot of every traced pipeline channel per enabled cycle
// into a circular buffer, freezes a programmable number of samples after a
// trigger, then replays the captured window oldest-first over a show-ahead
// read handshake. Each entry is {timestamp, stage_valid, stage_data}.

module pipe_trace_buffer #(
    parameter  int NUM_STAGES = 5,
    parameter  int STAGE_W    = 16,
    parameter  int DEPTH      = 32,   // power of two, >= 4
    parameter  int TS_W       = 16,
    localparam int AW         = $clog2(DEPTH),
    localparam int ENTRY_W    = TS_W + NUM_STAGES + NUM_STAGES*STAGE_W
) (
    input  logic                          clk,
    input  logic                          reset,       // asynchronous, active-low
    input  logic                          ce,
    input  logic                          arm,
    input  logic                          trig,
    input  logic [AW-1:0]                 post_cnt,
    input  logic [NUM_STAGES-1:0]         stage_valid,
    input  logic [NUM_STAGES*STAGE_W-1:0] stage_data,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [ENTRY_W-1:0]            rd_data,
    output logic [AW:0]                   count,
    output logic [AW:0]                   trig_ofs,
    output logic [1:0]                    state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_ARMED     = 2'b01,
        S_TRIGGERED = 2'b10,
        S_DONE      = 2'b11
    } state_t;

    localparam logic [AW:0] DEPTH_C    = (AW+1)'(DEPTH);
    localparam logic [AW:0] DEPTH_M1_C = (AW+1)'(DEPTH - 1);

    state_t               state_q;
    logic [TS_W-1:0]      ts_q;
    logic [AW-1:0]        wptr_q;
    logic [AW-1:0]        rptr_q;
    logic [AW:0]          count_q;
    logic [AW:0]          trig_ofs_q;
    logic [AW-1:0]        remaining_q;
    logic [ENTRY_W-1:0]   mem [DEPTH];

    logic                 capture;   // a sample is written this cycle
    logic                 fire;      // the trigger sample is written this cycle
    logic                 pop;       // one entry is consumed by the reader
    logic                 full;
    logic [AW:0]          trig_ofs_dec;
    logic [ENTRY_W-1:0]   wr_entry;

    assign wr_entry = {ts_q, stage_valid, stage_data};

    // Decode of the per-cycle actions; arm overrides capture, trigger and pop.
    always_comb begin
        // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
        capture      = 1'b0;
        fire         = 1'b0;
        pop          = 1'b0;
        full         = (count_q == DEPTH_C);
        trig_ofs_dec = (trig_ofs_q == '0) ? '0 : trig_ofs_q - 1'b1;
        if (!arm) begin
            capture = ce && ((state_q == S_ARMED) || (state_q == S_TRIGGERED));
            fire    = capture && trig && (state_q == S_ARMED);
            pop     = rd_en && (state_q == S_DONE) && (count_q != '0);
        end
    end

    // Free-running timestamp, advanced on every enabled cycle in any state.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
        if (!reset) begin
            ts_q <= '0;
        end else if (ce) begin
            ts_q <= ts_q + 1'b1;
        end
    end

    // Trace storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; its contents are only visible through count/rptr, which are reset.
        if (capture) begin
            mem[wptr_q] <= wr_entry;
        end
    end

    // Write/read pointers and occupancy; a full buffer drops its oldest entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (arm) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (capture) begin
            wptr_q <= wptr_q + 1'b1;
            if (full) begin
                rptr_q <= rptr_q + 1'b1;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end else if (pop) begin
            rptr_q  <= rptr_q + 1'b1;
            count_q <= count_q - 1'b1;
        end
    end

    // Capture FSM with post-trigger countdown and trigger-offset tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            trig_ofs_q  <= '0;
        end else if (arm) begin
            state_q     <= S_ARMED;
            remaining_q <= '0;
            trig_ofs_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_ARMED: begin
                    if (fire) begin
                        // The trigger sample lands after the current entries, or at
                        // the newest slot once the oldest one is dropped.
                        trig_ofs_q  <= full ? DEPTH_M1_C : count_q;
                        remaining_q <= post_cnt;
                        state_q     <= (post_cnt == '0) ? S_DONE : S_TRIGGERED;
                    end
                end
                S_TRIGGERED: begin
                    if (capture) begin
                        remaining_q <= remaining_q - 1'b1;
                        if (full) begin
                            trig_ofs_q <= trig_ofs_dec;
                        end
                        if (remaining_q == AW'(1)) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (pop) begin
                        trig_ofs_q <= trig_ofs_dec;
                        if (count_q == (AW+1)'(1)) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Show-ahead read port: oldest entry is presented only while frozen and non-empty.
    always_comb begin
        rd_valid = (state_q == S_DONE) && (count_q != '0);
        rd_data  = rd_valid ? mem[rptr_q] : '0;
    end

    assign count    = count_q;
    assign trig_ofs = trig_ofs_q;
    assign state    = state_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Self-checking bench for pipe_trace_buffer: directed scenarios plus a
// randomized soak, all compared every cycle against a queue-based model.

module tb_pipe_trace_buffer;

    localparam int NUM_STAGES = 5;
    localparam int STAGE_W    = 16;
    localparam int DEPTH      = 32;
    localparam int TS_W       = 16;
    localparam int AW         = $clog2(DEPTH);
    localparam int ENTRY_W    = TS_W + NUM_STAGES + NUM_STAGES*STAGE_W;

    typedef logic [ENTRY_W-1:0] entry_t;
    typedef struct {
        entry_t e;
        bit     is_trig;
    } rec_t;

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          ce;
    logic                          arm;
    logic                          trig;
    logic [AW-1:0]                 post_cnt;
    logic [NUM_STAGES-1:0]         stage_valid;
    logic [NUM_STAGES*STAGE_W-1:0] stage_data;
    logic                          rd_en;
    logic                          rd_valid;
    logic [ENTRY_W-1:0]            rd_data;
    logic [AW:0]                   count;
    logic [AW:0]                   trig_ofs;
    logic [1:0]                    state;

    pipe_trace_buffer #(
        .NUM_STAGES (NUM_STAGES),
        .STAGE_W    (STAGE_W),
        .DEPTH      (DEPTH),
        .TS_W       (TS_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .arm         (arm),
        .trig        (trig),
        .post_cnt    (post_cnt),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .rd_en       (rd_en),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .count       (count),
        .trig_ofs    (trig_ofs),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Reference model: the captured window as a queue, oldest first.
    rec_t q[$];
    int   m_state;   // 0 idle, 1 armed, 2 triggered, 3 done
    int   m_rem;
    int   m_ts;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input entry_t e, input bit t);
        rec_t r;
        r.e       = e;
        r.is_trig = t;
        q.push_back(r);
        if (q.size() > DEPTH) void'(q.pop_front());
    endfunction

    // Position of the trigger entry in the window; 0 once it is gone.
    function automatic int model_ofs();
        foreach (q[i]) if (q[i].is_trig) return i;
        return 0;
    endfunction

    function automatic entry_t model_rd();
        if (m_state == 3 && q.size() > 0) return q[0].e;
        return '0;
    endfunction

    task automatic model_step();
        entry_t e;
        e = {m_ts[TS_W-1:0], stage_valid, stage_data};
        if (arm) begin
            q.delete();
            m_state = 1;
        end else begin
            case (m_state)
                1: if (ce) begin
                    push(e, trig);
                    if (trig) begin
                        m_rem   = int'(post_cnt);
                        m_state = (m_rem == 0) ? 3 : 2;
                    end
                end
                2: if (ce) begin
                    push(e, 1'b0);
                    m_rem--;
                    if (m_rem == 0) m_state = 3;
                end
                3: if (rd_en && q.size() > 0) begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_state = 0;
                end
                default: ;
            endcase
        end
        if (ce) m_ts = (m_ts + 1) % (1 << TS_W);
    endtask

    task automatic compare_all();
        check("state",    128'(state),    128'(m_state));
        check("count",    128'(count),    128'(q.size()));
        check("trig_ofs", 128'(trig_ofs), 128'(model_ofs()));
        check("rd_valid", 128'(rd_valid), 128'((m_state == 3) && (q.size() > 0)));
        check("rd_data",  128'(rd_data),  128'(model_rd()));
    endtask

    task automatic set_inputs(input bit a, input bit t, input bit c, input bit r);
        arm         = a;
        trig        = t;
        ce          = c;
        rd_en       = r;
        stage_valid = NUM_STAGES'($urandom);
        for (int i = 0; i < NUM_STAGES; i++)
            stage_data[i*STAGE_W +: STAGE_W] = STAGE_W'($urandom);
        stage_data[STAGE_W-1:0] = m_ts[STAGE_W-1:0];
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #2;
        q.delete();
        m_state = 0;
        m_ts    = 0;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
    endtask

    function automatic logic [127:0] rd_ts();
        return 128'(rd_data[ENTRY_W-1 -: TS_W]);
    endfunction

    entry_t held;

    initial begin
        reset    = 1'b1;
        post_cnt = '0;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
        m_state  = 0;
        m_ts     = 0;
        m_rem    = 0;
        #3;
        do_reset();

        // Reset mid-capture.
        set_inputs(1'b1, 1'b0, 1'b0, 1'b0); cycle();
        for (int k = 0; k < 5; k++) begin set_inputs(1'b0, 1'b0, 1'b1, 1'b0); cycle(); end
        check("midcap_count_before", 128'(count), 128'(5));
        do_reset();
        check("rst_state",    128'(state),    128'(0));
        check("rst_count",    128'(count),    128'(0));
        check("rst_rd_valid", 128'(rd_valid), 128'(0));
        check("rst_rd_data",  128'(rd_data),  128'(0));

        // Pre/post window: trigger at ts=10, four post samples.
        post_cnt = AW'(4);
        set_inputs(1'b1, 1'b0, 1'b0, 1'b0); cycle();
        for (int k = 0; k < 15; k++) begin set_inputs(1'b0, k == 10, 1'b1, 1'b0); cycle(); end
        check("pp_state",    128'(state),    128'(3));
        check("pp_count",    128'(count),    128'(15));
        check("pp_trig_ofs", 128'(trig_ofs), 128'(10));
        for (int k = 0; k < 15; k++) begin
            check("pp_pop_ts", rd_ts(), 128'(k));
            set_inputs(1'b0, 1'b0, 1'($urandom), 1'b1); cycle();
        end
        check("pp_rd_valid_end", 128'(rd_valid), 128'(0));
        check("pp_state_end",    128'(state),    128'(0));

        // Wrap/overwrite: 40 pre samples (trigger is the 40th), three post.
        do_reset();
        post_cnt = AW'(3);
        set_inputs(1'b1, 1'b0, 1'b0, 1'b0); cycle();
        for (int k = 0; k < 43; k++) begin set_inputs(1'b0, k == 39, 1'b1, 1'b0); cycle(); end
        check("wrap_count",    128'(count),    128'(32));
        check("wrap_trig_ofs", 128'(trig_ofs), 128'(28));
        check("wrap_first_ts", rd_ts(),        128'(11));
        for (int k = 0; k < 32; k++) begin
            if (k == 31) check("wrap_last_ts", rd_ts(), 128'(42));
            set_inputs(1'b0, 1'b0, 1'b0, 1'b1); cycle();
        end
        check("wrap_state_end", 128'(state), 128'(0));

        // ce gating, then post_cnt=0 freeze and every-other-cycle readout.
        do_reset();
        set_inputs(1'b1, 1'b0, 1'b0, 1'b0); cycle();
        for (int k = 0; k < 2; k++) begin set_inputs(1'b0, 1'b0, 1'b1, 1'b0); cycle(); end
        for (int k = 0; k < 3; k++) begin
            set_inputs(1'b0, 1'b1, 1'b0, 1'b0); cycle();
            check("ceg_state", 128'(state), 128'(1));
            check("ceg_count", 128'(count), 128'(2));
        end
        set_inputs(1'b0, 1'b0, 1'b1, 1'b0); cycle();
        check("ceg_count_resume", 128'(count), 128'(3));
        post_cnt = '0;
        set_inputs(1'b0, 1'b1, 1'b1, 1'b0); cycle();
        check("p0_state",    128'(state),    128'(3));
        check("p0_count",    128'(count),    128'(4));
        check("p0_trig_ofs", 128'(trig_ofs), 128'(3));
        for (int k = 0; k < 4; k++) begin
            check("hs_ts", rd_ts(), 128'(k));
            held = rd_data;
            set_inputs(1'b0, 1'b0, 1'b1, 1'b0); cycle();
            check("hs_hold", 128'(rd_data), 128'(held));
            set_inputs(1'b0, 1'b0, 1'b1, 1'b1); cycle();
        end
        check("hs_state_end", 128'(state), 128'(0));

        // arm mid-readout abandons the window.
        set_inputs(1'b1, 1'b0, 1'b1, 1'b0); cycle();
        for (int k = 0; k < 3; k++) begin set_inputs(1'b0, k == 2, 1'b1, 1'b0); cycle(); end
        check("mid_done", 128'(state), 128'(3));
        set_inputs(1'b0, 1'b0, 1'b0, 1'b1); cycle();
        set_inputs(1'b1, 1'b0, 1'b0, 1'b1); cycle();
        check("mid_arm_state", 128'(state),    128'(1));
        check("mid_arm_count", 128'(count),    128'(0));
        check("mid_arm_valid", 128'(rd_valid), 128'(0));

        // post_cnt=31 with the trigger at count=5.
        do_reset();
        post_cnt = AW'(31);
        set_inputs(1'b1, 1'b0, 1'b0, 1'b0); cycle();
        for (int k = 0; k < 37; k++) begin set_inputs(1'b0, k == 5, 1'b1, 1'b0); cycle(); end
        check("p31_state",    128'(state),    128'(3));
        check("p31_count",    128'(count),    128'(32));
        check("p31_trig_ofs", 128'(trig_ofs), 128'(0));

        // Simultaneous arm and trigger while armed.
        post_cnt = '0;
        set_inputs(1'b1, 1'b0, 1'b0, 1'b0); cycle();
        for (int k = 0; k < 3; k++) begin set_inputs(1'b0, 1'b0, 1'b1, 1'b0); cycle(); end
        set_inputs(1'b1, 1'b1, 1'b1, 1'b0); cycle();
        check("at_state", 128'(state), 128'(1));
        check("at_count", 128'(count), 128'(0));
        for (int k = 0; k < 3; k++) begin set_inputs(1'b0, 1'b0, 1'b1, 1'b0); cycle(); end
        check("at_state_after", 128'(state), 128'(1));
        check("at_count_after", 128'(count), 128'(3));

        // Randomized soak.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            post_cnt = AW'($urandom_range(0, DEPTH - 1));
            set_inputs((m_state == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0),
                       $urandom_range(0, 15) == 0,
                       $urandom_range(0, 3) != 0,
                       $urandom_range(0, 1) == 1);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
- Synthesisable, parametrised pipeline trace capture unit sitting beside the processor.
- Samples per-stage snapshots every enabled cycle into a circular buffer: IF/ID, ID/EX, EX/MEM, MEM/WB, or any NUM_STAGES channels.
- Freezes on a trigger after a programmable post-trigger count.
- Replays the captured window oldest-first over a show-ahead read handshake, replacing $display-style monitoring with a hardware logic analyser.

Parameters:
- NUM_STAGES, 5, number of traced pipeline channels.
- STAGE_W, 16, bits per channel snapshot.
- DEPTH, 32, trace entries; power of two, >= 4.
- TS_W, 16, timestamp width.
- Derived: AW = $clog2(DEPTH); ENTRY_W = TS_W + NUM_STAGES + NUM_STAGES*STAGE_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable. Gates capture, timestamp and post-count only.
- arm  in  1  single-cycle pulse: clear buffer, start capture.
- trig  in  1  trigger request, honoured only in ARMED.
- post_cnt  in  AW  samples to capture after the trigger sample. Sampled when the trigger fires.
- stage_valid  in  NUM_STAGES  per-channel valid bits.
- stage_data  in  NUM_STAGES*STAGE_W  channel i at bits [i*STAGE_W +: STAGE_W].
- rd_en  in  1  pop request.
- rd_valid  out  1  rd_data holds an unread entry.
- rd_data  out  ENTRY_W  {timestamp, stage_valid, stage_data} of the oldest entry.
- count  out  AW+1  entries currently held, 0..DEPTH.
- trig_ofs  out  AW+1  index of the trigger entry counted from the oldest entry at freeze.
- state  out  2  00 IDLE, 01 ARMED, 10 TRIGGERED, 11 DONE.

Behaviour:
Reset (reset low, asynchronous):
- state=IDLE; count, trig_ofs, timestamp, write and read pointers = 0.
- rd_valid=0; rd_data=0.
- Buffer contents don't-care.

Timestamp:
- Increments by 1 on every clk with ce=1 in any state.
- Wraps 2^TS_W-1 -> 0.
- Each entry carries the pre-increment value.

IDLE:
- No writes.
- arm -> ARMED.
- trig ignored.

ARMED:
- Each ce=1 cycle writes one entry at wptr; wptr increments mod DEPTH.
- count increments, saturating at DEPTH.
- When full, the oldest entry is overwritten and rptr advances with wptr.
- trig=1 with ce=1:
  - That cycle's sample is written as the trigger entry.
  - trig_ofs = count before the write, or DEPTH-1 if count was already DEPTH.
  - Internal remaining counter loaded with post_cnt.
  - Next state TRIGGERED, or DONE if post_cnt==0.
- trig with ce=0: ignored; no sample is taken.

TRIGGERED:
- Each ce=1 cycle writes one entry and decrements remaining.
- The write that takes remaining 1 -> 0 moves to DONE.
- Exactly post_cnt post-trigger entries are captured.
- trig ignored.
- post_cnt can overwrite pre-trigger history. Whenever an entry is overwritten, trig_ofs decrements, saturating at 0; it stays exact while the trigger entry survives.

DONE:
- No writes.
- rd_valid = (count != 0).
- rd_data is combinational from the entry at rptr (show-ahead).
- rd_en && rd_valid pops: rptr++ mod DEPTH, count--, trig_ofs decrements, saturating at 0.
- The next entry is presented in the following cycle.
- rd_en with rd_valid=0 has no effect.
- The pop that empties the buffer moves to IDLE.
- Readout is independent of ce.

Outside DONE:
- rd_valid=0; rd_data holds 0.
- rd_en ignored.

arm in any state:
- Next state ARMED; count, trig_ofs, pointers = 0.
- Timestamp not cleared.
- A readout in progress is abandoned.
- arm and trig in the same cycle: arm wins, trig dropped.
- No sample is written in the arm cycle.

Test Plan:
- Reset mid-capture: pulse arm, 5 ce cycles, drop reset -> next cycle state=00, count=0, rd_valid=0, rd_data=0.
- Pre/post window, defaults:
  - Stimulus: arm at ts=0; stage_data channel0 = ts; trig at ts=10; post_cnt=4.
  - Required: DONE after ts=14; count=15; trig_ofs=10; pops return ts 0..14 in order; rd_valid falls after the 15th pop; state returns to IDLE.
- Wrap/overwrite:
  - Stimulus: arm, 40 ce cycles, trig at cycle 40, post_cnt=3.
  - Required: count=32; first pop ts=11; trig_ofs=28; last pop ts=42.
- ce gating:
  - Stimulus: ARMED, ce low 3 cycles with trig=1 held throughout, then ce high with trig=0.
  - Required: no entries and no timestamp advance while ce low; state stays ARMED.
- Readout handshake, from DONE with count=4:
  - Stimulus: rd_en high every other cycle.
  - Required: 4 distinct entries in order; rd_data stable while rd_en low.
  - Follow-up: arm asserted mid-readout -> state ARMED, count=0 next cycle.
- Edge cases:
  - post_cnt=0 -> DONE in the trigger cycle; last entry = trigger sample.
  - post_cnt=31 with trig at count=5 -> count=32, trig_ofs=0 at freeze.
  - Simultaneous arm+trig in ARMED -> ARMED, count=0, no DONE.
